// File: rtl/alu_result_serializer.sv
// Serializes a 17-bit ALU result plus its 2-bit op code into a three-byte frame:
// low byte, middle byte, then {tag, 5'b0, result[16]} flagged as the last byte.
module alu_result_serializer #(
    parameter int TAG_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [16:0]      i_result,
    input  logic [1:0]       i_control,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic             o_last,
    output logic [CNT_W-1:0] o_frame_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] B0   = 2'd1;
    localparam logic [1:0] B1   = 2'd2;
    localparam logic [1:0] B2   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [16:0] held_result;
    logic [1:0]  held_control;
    logic [1:0]  tag;
    logic        accept;
    logic        handoff;

    // A new word may enter while the last byte is being taken, so frames run gap-free
    assign handoff = (state == B2) && i_byte_ready;
    assign o_ready = (state == IDLE) || handoff;
    assign accept  = i_valid && o_ready;
    assign tag     = (TAG_EN != 0) ? held_control : 2'b00;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = B0;
            B0:   if (i_byte_ready) state_next = B1;
            B1:   if (i_byte_ready) state_next = B2;
            B2:   if (i_byte_ready) state_next = accept ? B0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            held_result  <= '0;
            held_control <= '0;
            o_frame_cnt  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                held_result  <= i_result;
                held_control <= i_control;
            end
            if (handoff) begin
                o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        o_byte       = 8'h00;
        o_byte_valid = 1'b0;
        o_last       = 1'b0;
        case (state)
            B0: begin
                o_byte       = held_result[7:0];
                o_byte_valid = 1'b1;
            end
            B1: begin
                o_byte       = held_result[15:8];
                o_byte_valid = 1'b1;
            end
            B2: begin
                o_byte       = {tag, 5'b00000, held_result[16]};
                o_byte_valid = 1'b1;
                o_last       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: a queue-of-pending-bytes reference model predicts
// every output each cycle; a second instance with TAG_EN=0 checks tag masking.
module tb_alu_result_serializer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [16:0] i_result;
    logic [1:0]  i_control;
    logic        i_valid;
    logic        i_byte_ready;

    logic        o_ready, o_byte_valid, o_last;
    logic [7:0]  o_byte;
    logic [7:0]  o_frame_cnt;

    logic        nt_ready, nt_byte_valid, nt_last;
    logic [7:0]  nt_byte;
    logic [7:0]  nt_frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  model_q[$];
    logic [7:0]  model_cnt = 8'd0;
    logic [26:0] obs_vec, exp_vec;
    logic        seen_ready, seen_last;
    logic [7:0]  seen_byte, seen_nt_byte, seen_cnt;

    always #5 i_clk = ~i_clk;

    alu_result_serializer #(.TAG_EN(1), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_result(i_result), .i_control(i_control),
        .i_valid(i_valid), .o_ready(o_ready), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
        .i_byte_ready(i_byte_ready), .o_last(o_last), .o_frame_cnt(o_frame_cnt)
    );

    alu_result_serializer #(.TAG_EN(0), .CNT_W(8)) dut_notag (
        .i_clk(i_clk), .i_rst(i_rst), .i_result(i_result), .i_control(i_control),
        .i_valid(i_valid), .o_ready(nt_ready), .o_byte(nt_byte), .o_byte_valid(nt_byte_valid),
        .i_byte_ready(i_byte_ready), .o_last(nt_last), .o_frame_cnt(nt_frame_cnt)
    );

    // One clock of stimulus: predict outputs from the model, sample the DUT, then advance the model
    task automatic drive(input logic v, input logic [16:0] r, input logic [1:0] c,
                         input logic br, input logic rs);
        logic       e_ready, e_valid, e_last, took_last;
        logic [7:0] e_byte;
        i_valid = v; i_result = r; i_control = c; i_byte_ready = br; i_rst = rs;
        #2;
        if (model_q.size() == 0) begin
            e_valid = 1'b0; e_byte = 8'h00; e_last = 1'b0; e_ready = 1'b1;
        end else begin
            e_valid = 1'b1; e_byte = model_q[0]; e_last = (model_q.size() == 1);
            e_ready = e_last && br;
        end
        exp_vec = {e_ready, e_valid, e_byte, e_last, model_cnt, (e_last ? (e_byte & 8'h3F) : e_byte)};
        obs_vec = {o_ready, o_byte_valid, o_byte, o_last, o_frame_cnt, nt_byte};
        seen_ready = o_ready; seen_last = o_last; seen_byte = o_byte;
        seen_nt_byte = nt_byte; seen_cnt = o_frame_cnt;
        @(posedge i_clk);
        #1;
        if (rs) begin
            model_q.delete();
            model_cnt = 8'd0;
        end else begin
            took_last = 1'b0;
            if (br && model_q.size() != 0) begin
                took_last = (model_q.size() == 1);
                void'(model_q.pop_front());
            end
            if (took_last) model_cnt = model_cnt + 8'd1;
            if (v && e_ready) begin
                model_q.push_back(r[7:0]);
                model_q.push_back(r[15:8]);
                model_q.push_back({c, 5'b00000, r[16]});
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b1);
        drive(1'b1, 17'h1FFFF, 2'd3, 1'b1, 1'b1);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (obs_vec !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %h expected %h", obs_vec, {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] want [3];
        logic [7:0] got  [3];
        logic       lst  [3];
        want[0] = 8'hCD; want[1] = 8'hAB; want[2] = 8'h41;
        drive(1'b1, 17'h1ABCD, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
            got[i] = seen_byte; lst[i] = seen_last;
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL single_frame cycle %0d got %h expected %h", i, obs_vec, exp_vec);
            end
            vectors++;
            if (got[i] !== want[i] || lst[i] !== (i == 2)) begin
                miscompares++;
                $display("[TB] FAIL single_frame byte %0d got %h last %b expected %h last %b",
                         i, got[i], lst[i], want[i], (i == 2));
            end
        end
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (seen_cnt !== 8'd1 || obs_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL single_frame_count got %h expected %h (cnt %0d vs 1)", obs_vec, exp_vec, seen_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [6];
        want[0] = 8'h12; want[1] = 8'h00; want[2] = 8'h00;
        want[3] = 8'h34; want[4] = 8'h00; want[5] = 8'hC1;
        drive(1'b1, 17'h00012, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, 17'h10034, 2'd3, 1'b1, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec || seen_byte !== want[i]) begin
                miscompares++;
                $display("[TB] FAIL back_to_back cycle %0d got %h expected %h (byte %h vs %h)",
                         i, obs_vec, exp_vec, seen_byte, want[i]);
            end
            if (i == 2) begin
                vectors++;
                if (seen_ready !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL back_to_back_ready got %b expected 1", seen_ready);
                end
            end
        end
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        drive(1'b1, 17'h1ABCD, 2'd1, 1'b1, 1'b0);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 17'($urandom), 2'($urandom), 1'b0, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec || seen_byte !== 8'hAB || seen_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL stall cycle %0d got %h expected %h (byte %h vs ab, ready %b vs 0)",
                         i, obs_vec, exp_vec, seen_byte, seen_ready);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL stall_resume cycle %0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b1);
        drive(1'b1, 17'h1ABCD, 2'd1, 1'b1, 1'b0);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b1);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (obs_vec !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_frame got %h expected %h", obs_vec, {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
        end
        drive(1'b1, 17'h05A3C, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
            vectors++;
            if (obs_vec !== exp_vec || (i == 0 && seen_byte !== 8'h3C)) begin
                miscompares++;
                $display("[TB] FAIL reset_restart cycle %0d got %h expected %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_tag();
        drive(1'b1, 17'h10000, 2'd3, 1'b1, 1'b0);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (seen_nt_byte !== 8'h01 || seen_byte !== 8'hC1 || obs_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL tag_byte2 got notag %h tag %h expected 01 c1", seen_nt_byte, seen_byte);
        end
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_counter_wrap();
        logic [7:0] cnt_before;
        cnt_before = 8'hxx;
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b1);
        drive(1'b1, 17'($urandom), 2'($urandom), 1'b1, 1'b0);
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 3; i++) begin
                drive(!(f == 255 && i == 2), 17'($urandom), 2'($urandom), 1'b1, 1'b0);
                if (f == 255 && i == 2) cnt_before = seen_cnt;
                vectors++;
                if (obs_vec !== exp_vec) begin
                    miscompares++;
                    $display("[TB] FAIL wrap frame %0d byte %0d got %h expected %h", f, i, obs_vec, exp_vec);
                end
            end
        end
        drive(1'b0, 17'h0, 2'd0, 1'b1, 1'b0);
        vectors++;
        if (cnt_before !== 8'd255 || seen_cnt !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_count got %0d then %0d expected 255 then 0", cnt_before, seen_cnt);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom % 2) == 0, 17'($urandom), 2'($urandom),
                  ($urandom % 10) < 7, ($urandom % 64) == 0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d got %h expected %h", n, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_tag();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
